// File: rtl/uart_rx_ctrl_if.sv
// Core-side and line-side signals of the UART receive controller.
interface uart_rx_ctrl_if;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       clear_err;
  logic       busy;

  modport master (input uart_rx, rx_ready, clear_err,
                  output rx_data, rx_valid, frame_err, overrun, busy);
  modport slave  (output uart_rx, rx_ready, clear_err,
                  input rx_data, rx_valid, frame_err, overrun, busy);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled 8N1 frame sequencing, error flags and a small byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check.
module uart_rx_ctrl #(
  parameter int CLK_FREQUENCY_HZ = 100_000_000,
  parameter int BAUD             = 9600,
  parameter int OVERSAMPLE       = 16,
  parameter int FIFO_DEPTH       = 4
) (
  input logic            clk,
  input logic            rst,
  uart_rx_ctrl_if.master bus
);
  localparam int DIV_RAW = CLK_FREQUENCY_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t          state, state_n;
  logic            rx_m, rx_s;
  logic [DW-1:0]   div_cnt;
  logic [SW-1:0]   s_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      sh;
  logic            par_bad;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            fe_q, ov_q;
  logic            tick, mid, ctr, full, pop;
  logic            enter_start, push, set_fe, set_ov;

  assign tick = (div_cnt == DW'(DIV - 1));
  assign mid  = (s_cnt == SW'(OVERSAMPLE / 2 - 1));
  assign ctr  = (s_cnt == SW'(OVERSAMPLE - 1));
  assign full = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop  = bus.rx_valid && bus.rx_ready;

  assign bus.rx_data   = mem[rd_ptr];
  assign bus.rx_valid  = (count != '0);
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ov_q;
  assign bus.busy      = (state != IDLE);

  always_comb begin
    state_n     = state;
    enter_start = 1'b0;
    push        = 1'b0;
    set_fe      = 1'b0;
    set_ov      = 1'b0;
    case (state)
      IDLE:  if (!rx_s) begin state_n = START; enter_start = 1'b1; end
      START: if (tick && mid) state_n = rx_s ? IDLE : DATA;
      DATA:  if (tick && ctr && bit_cnt == 3'd7) state_n = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick && ctr) begin
        state_n = STOP;
        set_fe  = (^sh) ^ rx_s;
      end
`endif
      STOP: if (tick && ctr) begin
        if (!rx_s) begin
          state_n = BREAK;
          set_fe  = 1'b1;
        end else begin
          // Returning to IDLE on the sample cycle lets a back-to-back start bit be seen.
          state_n = IDLE;
          if (!par_bad) begin
            if (full && !pop) set_ov = 1'b1;
            else              push   = 1'b1;
          end
        end
      end
      BREAK:   if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      div_cnt <= '0;
      s_cnt   <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      par_bad <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      rx_m  <= bus.uart_rx;
      rx_s  <= rx_m;

      if (enter_start || tick) div_cnt <= '0;
      else                     div_cnt <= div_cnt + DW'(1);

      if (enter_start) begin
        s_cnt   <= '0;
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end else if (tick && state != IDLE && state != BREAK) begin
        if ((state == START && mid) || ctr) s_cnt <= '0;
        else                                s_cnt <= s_cnt + SW'(1);
      end

      if (state == DATA && tick && ctr) begin
        sh      <= {rx_s, sh[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && tick && ctr) par_bad <= (^sh) ^ rx_s;
`endif

      if (push) begin
        mem[wr_ptr] <= sh;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase

      // A set in the same cycle as clear_err wins.
      fe_q <= set_fe | (fe_q & ~bus.clear_err);
      ov_q <= set_ov | (ov_q & ~bus.clear_err);
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboarded bench for uart_rx_ctrl at 16 clk per bit.
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(
    .CLK_FREQUENCY_HZ(1_600_000),
    .BAUD(100_000),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Clock edge (counted from the start-bit drive) on which the stop bit is sampled.
  localparam int STOP_CLK = 155 + 16 * PB;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.uart_rx = b;
    step(16);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v = 1'b1,
                      input int stop_n = 1, input logic par_flip = 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PB != 0) drive_bit((^d) ^ par_flip);
    repeat (stop_n) drive_bit(stop_v);
    bus.uart_rx = 1'b1;
  endtask

  task automatic drain(input int n);
    bus.rx_ready = 1'b1;
    step(n);
    bus.rx_ready = 1'b0;
  endtask

  task automatic clr_err();
    bus.clear_err = 1'b1;
    step(1);
    bus.clear_err = 1'b0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst && bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got %0h want none", bus.rx_data);
        end else begin
          chk("pop_data", {24'h0, bus.rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  endtask

  logic [7:0] d99;

  initial begin
    bus.uart_rx   = 1'b1;
    bus.rx_ready  = 1'b0;
    bus.clear_err = 1'b0;
    fork monitor(); join_none

    // reset state
    step(3);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_data", bus.rx_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_ovr", bus.overrun, 0);
    rst = 1'b1;
    step(5);

    // 1: single good frame
    exp_q.push_back(8'hA5);
    send(8'hA5);
    chk("t1_valid", bus.rx_valid, 1);
    chk("t1_data", bus.rx_data, 32'hA5);
    chk("t1_ferr", bus.frame_err, 0);
    chk("t1_ovr", bus.overrun, 0);
    chk("t1_busy", bus.busy, 0);
    drain(2);
    chk("t1_empty", bus.rx_valid, 0);

    // 2: glitch is a false start
    bus.uart_rx = 1'b0;
    step(4);
    bus.uart_rx = 1'b1;
    chk("t2_busy_start", bus.busy, 1);
    step(8);
    chk("t2_busy_idle", bus.busy, 0);
    chk("t2_valid", bus.rx_valid, 0);
    step(10);

    // 3: stop bit low -> framing error, break, recovery
    send(8'h3C, 1'b0, 2);
    chk("t3_ferr", bus.frame_err, 1);
    chk("t3_valid", bus.rx_valid, 0);
    chk("t3_busy_break", bus.busy, 1);
    step(20);
    chk("t3_busy_idle", bus.busy, 0);
    exp_q.push_back(8'h55);
    send(8'h55);
    chk("t3_valid55", bus.rx_valid, 1);
    drain(2);
    chk("t3_ferr_sticky", bus.frame_err, 1);
    clr_err();
    chk("t3_ferr_clr", bus.frame_err, 0);

    // 4: overrun on the fifth back-to-back frame
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    for (int k = 1; k <= 5; k++) send(8'(k));
    chk("t4_ovr", bus.overrun, 1);
    chk("t4_head", bus.rx_data, 32'h01);
    chk("t4_ferr", bus.frame_err, 0);
    drain(4);
    chk("t4_drained", bus.rx_valid, 0);
    clr_err();
    chk("t4_ovr_clr", bus.overrun, 0);

    // 5: pop coincides with push on a full FIFO
    exp_q.push_back(8'h11); send(8'h11);
    exp_q.push_back(8'h22); send(8'h22);
    exp_q.push_back(8'h33); send(8'h33);
    exp_q.push_back(8'h44); send(8'h44);
    exp_q.push_back(8'h77);
    fork
      send(8'h77);
      begin
        step(STOP_CLK - 1);
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
      end
    join
    chk("t5_ovr", bus.overrun, 0);
    chk("t5_head", bus.rx_data, 32'h22);
    send(8'h88);
    chk("t5_ovr_full", bus.overrun, 1);

    // 6: reset in the middle of a data bit
    d99 = 8'h99;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d99[i]);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    exp_q.delete();
    chk("t6_valid", bus.rx_valid, 0);
    chk("t6_data", bus.rx_data, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_ovr", bus.overrun, 0);
    chk("t6_ferr", bus.frame_err, 0);
    step(5);
    exp_q.push_back(8'h42);
    send(8'h42);
    drain(2);
`ifdef UART_RX_PARITY_EN
    send(8'h42, 1'b1, 1, 1'b1);
    chk("t6_par_ferr", bus.frame_err, 1);
    chk("t6_par_valid", bus.rx_valid, 0);
`endif
    step(4);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
